mem_stream_port: RTL



---
 rtl/mem_stream_pkg.sv | 21 ++
 rtl/mem_stream_fifo2.sv | 59 +++++
 rtl/mem_stream_port.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// ============================================================================
// Module   : mem_stream_pkg
// Brief    : Shared state encoding and default widths for the stream port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stream_pkg;

    localparam int c_DEF_AW = 4;
    localparam int c_DEF_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_stream_fifo2.sv
// ============================================================================
// Module   : mem_stream_fifo2
// Brief    : Two-entry first-word-fall-through FIFO buffering DUMP read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stream_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] r_slot_q [2];
    logic          r_wr_q;
    logic          r_rd_q;
    logic [1:0]    r_count_q;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = pop_i && (r_count_q != 2'd0);
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_push = push_i && ((r_count_q != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_q[0] <= '0;
            r_slot_q[1] <= '0;
            r_wr_q      <= 1'b0;
            r_rd_q      <= 1'b0;
            r_count_q   <= 2'd0;
        end else begin
            if (w_push) begin
                r_slot_q[r_wr_q] <= push_data_i;
                r_wr_q           <= ~r_wr_q;
            end
            if (w_pop) begin
                r_rd_q <= ~r_rd_q;
            end
            case ({w_push, w_pop})
                2'b10:   r_count_q <= r_count_q + 2'd1;
                2'b01:   r_count_q <= r_count_q - 2'd1;
                default: r_count_q <= r_count_q;
            endcase
        end
    end

    assign head_o  = r_slot_q[r_rd_q];
    assign count_o = r_count_q;

endmodule

`default_nettype wire

// File: rtl/mem_stream_port.sv
// ============================================================================
// Module   : mem_stream_port
// Brief    : Streams a word range into (LOAD) or out of (DUMP) a 16x8
//            synchronous-read memory over valid/ready byte streams.
// Options  : MEM_STREAM_CHECKSUM_EN adds the per-command XOR checksum output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stream_port
    import mem_stream_pkg::*;
#(
    parameter int AW = c_DEF_AW,
    parameter int DW = c_DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          done,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_dat_w,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dat_r
`ifdef MEM_STREAM_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [AW-1:0] c_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        r_state_q;
    logic [AW-1:0] r_ptr_q;
    logic [AW-1:0] r_issue_left_q;
    logic [AW-1:0] r_out_left_q;
    logic          r_issuing_q;
    logic          r_rd_pend_q;
    logic          r_done_q;

    logic          w_cmd_hs;
    logic          w_in_hs;
    logic          w_pop;
    logic          w_issue;
    logic [1:0]    w_fifo_count;
    logic [DW-1:0] w_fifo_head;
    logic [2:0]    w_occ;

    assign w_cmd_hs  = cmd_valid && (r_state_q == ST_IDLE);
    assign w_in_hs   = in_valid && (r_state_q == ST_LOAD);
    assign out_valid = (r_state_q == ST_DUMP) && (w_fifo_count != 2'd0);
    assign w_pop     = out_valid && out_ready;

    // Words owned by the port after this cycle; a word leaving now frees its
    // slot for a new read so a steady stream runs at one word per cycle.
    assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_rd_pend_q} - {2'b00, w_pop};
    assign w_issue = (r_state_q == ST_DUMP) && r_issuing_q && (w_occ < 3'd2);

    mem_stream_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (r_rd_pend_q),
        .push_data_i (mem_dat_r),
        .pop_i       (w_pop),
        .head_o      (w_fifo_head),
        .count_o     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_ptr_q        <= '0;
            r_issue_left_q <= '0;
            r_out_left_q   <= '0;
            r_issuing_q    <= 1'b0;
            r_rd_pend_q    <= 1'b0;
            r_done_q       <= 1'b0;
        end else begin
            r_done_q    <= 1'b0;
            r_rd_pend_q <= w_issue;
            case (r_state_q)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_ptr_q        <= cmd_base;
                        r_issue_left_q <= cmd_len;
                        r_out_left_q   <= cmd_len;
                        r_issuing_q    <= !cmd_load;
                        r_state_q      <= cmd_load ? ST_LOAD : ST_DUMP;
                    end
                end
                ST_LOAD: begin
                    if (w_in_hs) begin
                        r_ptr_q        <= r_ptr_q + c_ONE;
                        r_issue_left_q <= r_issue_left_q - c_ONE;
                        if (r_issue_left_q == '0) begin
                            r_state_q <= ST_IDLE;
                            r_done_q  <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (w_issue) begin
                        r_ptr_q <= r_ptr_q + c_ONE;
                        if (r_issue_left_q == '0) begin
                            r_issuing_q <= 1'b0;
                        end else begin
                            r_issue_left_q <= r_issue_left_q - c_ONE;
                        end
                    end
                    if (w_pop) begin
                        if (r_out_left_q == '0) begin
                            r_state_q <= ST_IDLE;
                            r_done_q  <= 1'b1;
                        end else begin
                            r_out_left_q <= r_out_left_q - c_ONE;
                        end
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state_q == ST_IDLE);
    assign in_ready  = (r_state_q == ST_LOAD);
    assign mem_we    = w_in_hs;
    assign mem_adr   = (r_state_q == ST_IDLE) ? '0 : r_ptr_q;
    assign mem_dat_w = (r_state_q == ST_LOAD) ? in_data : '0;
    assign out_data  = out_valid ? w_fifo_head : '0;
    assign done      = r_done_q;

`ifdef MEM_STREAM_CHECKSUM_EN
    logic [DW-1:0] r_csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum_q <= '0;
        end else if (w_cmd_hs) begin
            r_csum_q <= '0;
        end else if (w_in_hs) begin
            r_csum_q <= r_csum_q ^ in_data;
        end else if (w_pop) begin
            r_csum_q <= r_csum_q ^ out_data;
        end
    end

    assign checksum = r_csum_q;
`endif

endmodule

`default_nettype wire
